// File: rtl/ascii_pkg.sv
// Shared ASCII definitions for the case-conversion blocks.
// Holds the letter bounds, the case bit position and the byte type.
package ascii_pkg;

    typedef logic [7:0] ascii_t;

    localparam ascii_t ASCII_UC_A     = 8'h41;
    localparam ascii_t ASCII_UC_Z     = 8'h5A;
    localparam int     ASCII_CASE_BIT = 5;
    localparam ascii_t ASCII_NUL      = 8'h00;

endpackage

// File: rtl/to_lower_gate.sv
// Gate-level upper-to-lower ASCII mapper, the mirror image of the toUpper gate.
// Sets the case bit only for 'A'..'Z' and passes every other byte through.
module to_lower_gate
    import ascii_pkg::*;
(
    input  ascii_t ascii_in,
    output ascii_t ascii_out,
    output logic   is_upper
);

    wire       n_b7;
    wire       n_b5;
    wire       low_nz;
    wire       low_b10;
    wire       low_b210;
    wire       low_gt26;
    wire       low_le26;
    wire       upper_w;
    wire [7:0] out_w;

    // 0x41..0x5A is 010x_xxxx with the low five bits in 1..26
    not g_n7  (n_b7, ascii_in[7]);
    not g_n5  (n_b5, ascii_in[5]);
    or  g_nz  (low_nz, ascii_in[4], ascii_in[3], ascii_in[2], ascii_in[1], ascii_in[0]);
    and g_b10 (low_b10, ascii_in[1], ascii_in[0]);
    or  g_b2  (low_b210, ascii_in[2], low_b10);
    and g_gt  (low_gt26, ascii_in[4], ascii_in[3], low_b210);
    not g_le  (low_le26, low_gt26);
    and g_up  (upper_w, n_b7, ascii_in[6], n_b5, low_nz, low_le26);

    for (genvar i = 0; i < 8; i++) begin : g_bit
        if (i == ASCII_CASE_BIT) begin : g_case
            or g_or (out_w[i], ascii_in[i], upper_w);
        end else begin : g_pass
            buf g_buf (out_w[i], ascii_in[i]);
        end
    end

    assign ascii_out = out_w;
    assign is_upper  = upper_w;

endmodule

// File: rtl/to_lower_stream.sv
// Streaming ASCII lower-case converter with a small output FIFO and byte statistics.
// Bytes are converted on the way in, buffered, and returned oldest first.
module to_lower_stream
    import ascii_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] byte_cnt,
    output logic [CNT_W-1:0] conv_cnt
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PARTIAL = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    ascii_t           mem [DEPTH];
    logic [1:0]       state;
    ascii_t           conv_byte;
    logic             conv_upper;
    logic             push;
    logic             pop;

    to_lower_gate u_gate (
        .ascii_in  (in_data),
        .ascii_out (conv_byte),
        .is_upper  (conv_upper)
    );

    // Occupancy is read straight off the extra pointer bit; no separate count register
    always_comb begin
        state = ST_PARTIAL;
        if (wr_ptr == rd_ptr) begin
            state = ST_EMPTY;
        end else if ((wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                     (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0])) begin
            state = ST_FULL;
        end
    end

    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem[rd_ptr[IDX_W-1:0]] : ASCII_NUL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: it is only visible through out_data while out_valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[IDX_W-1:0]] <= conv_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            conv_cnt <= '0;
        end else if (cnt_clr) begin
            byte_cnt <= '0;
            conv_cnt <= '0;
        end else if (push) begin
            byte_cnt <= byte_cnt + 1'b1;
            conv_cnt <= conv_cnt + {{(CNT_W-1){1'b0}}, conv_upper};
        end
    end

endmodule

// File: tb/tb_to_lower_stream.sv
// Bench for to_lower_stream: directed scenarios plus random traffic,
// with a scoreboard queue filled on accepted input and drained by an output monitor.
module tb_to_lower_stream;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_data = 8'h00;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [7:0]       out_data;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] conv_cnt;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         m_bytes = 0;
    int         m_convs = 0;
    logic       hold_v = 1'b0;
    logic [7:0] hold_d = 8'h00;

    to_lower_stream #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cnt_clr   (cnt_clr),
        .byte_cnt  (byte_cnt),
        .conv_cnt  (conv_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_lower(input logic [7:0] b);
        if (b >= 8'd65 && b <= 8'd90) return b + 8'd32;
        return b;
    endfunction

    function automatic logic [31:0] wrap_cnt(input int v);
        return 32'(v % (1 << CNT_W));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus; the model sees exactly what the handshake accepts
    task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic clr);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        cnt_clr   = clr;
        @(negedge clk);
        if (in_valid && in_ready) begin
            exp_q.push_back(ref_lower(in_data));
        end
        if (cnt_clr) begin
            m_bytes = 0;
            m_convs = 0;
        end else if (in_valid && in_ready) begin
            m_bytes++;
            if (in_data >= 8'd65 && in_data <= 8'd90) m_convs++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            n++;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_byte_cnt"}, {28'd0, byte_cnt}, wrap_cnt(m_bytes));
        chk({tag, "_conv_cnt"}, {28'd0, conv_cnt}, wrap_cnt(m_convs));
    endtask

    // Output monitor: compares every pop and checks that stalled output holds still
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    chk("stall_valid", {31'd0, out_valid}, 32'd1);
                    chk("stall_data", {24'd0, out_data}, {24'd0, hold_d});
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out_unexpected: got %0h expected no output", out_data);
                    end else begin
                        chk("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
                    end
                end
                hold_v = out_valid && !out_ready;
                hold_d = out_data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic [7:0] map_in [8];
        map_in = '{8'd65, 8'd90, 8'd64, 8'd91, 8'd97, 8'd122, 8'd193, 8'd127};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk_counters("rst");

        // Mapping table
        foreach (map_in[i]) step(1'b1, map_in[i], 1'b1, 1'b0);
        drain();
        chk_counters("map");

        // Backpressure with HELLO
        step(1'b1, 8'h48, 1'b0, 1'b0);
        chk("bp_ready1", {31'd0, in_ready}, 32'd1);
        step(1'b1, 8'h45, 1'b0, 1'b0);
        step(1'b1, 8'h4C, 1'b0, 1'b0);
        chk("bp_ready3", {31'd0, in_ready}, 32'd1);
        step(1'b1, 8'h4C, 1'b0, 1'b0);
        chk("bp_full", {31'd0, in_ready}, 32'd0);
        step(1'b1, 8'h4F, 1'b0, 1'b0);
        step(1'b1, 8'h4F, 1'b0, 1'b0);
        chk("bp_o_refused", {31'd0, in_ready}, 32'd0);
        chk("bp_queue4", 32'(exp_q.size()), 32'd4);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("bp_ready_after_pop", {31'd0, in_ready}, 32'd1);
        drain();

        // Simultaneous push and pop at two entries, wrapping the pointers
        step(1'b1, 8'h31, 1'b0, 1'b0);
        step(1'b1, 8'h4B, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
            chk("pp_valid", {31'd0, out_valid}, 32'd1);
            chk("pp_ready", {31'd0, in_ready}, 32'd1);
        end
        drain();

        // One-cycle latency into an empty FIFO
        step(1'b1, 8'h4D, 1'b0, 1'b0);
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_data", {24'd0, out_data}, 32'h6D);
        drain();

        // Asynchronous reset with bytes buffered
        step(1'b1, 8'h52, 1'b0, 1'b0);
        step(1'b1, 8'h53, 1'b0, 1'b0);
        step(1'b1, 8'h54, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        m_bytes = 0;
        m_convs = 0;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_data", {24'd0, out_data}, 32'd0);
        chk_counters("arst");
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        step(1'b1, 8'h51, 1'b1, 1'b0);
        chk("arst_first_data", {24'd0, out_data}, {24'd0, ref_lower(8'h51)});
        drain();

        // Counter wrap and clear priority
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk_counters("clr_idle");
        for (int i = 0; i < 17; i++) step(1'b1, 8'h41, 1'b1, 1'b0);
        chk_counters("wrap17");
        chk("wrap17_byte_lit", {28'd0, byte_cnt}, 32'd1);
        step(1'b1, 8'h42, 1'b1, 1'b1);
        chk_counters("clr_push");
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 60) == 0));
        end
        drain();
        chk_counters("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
